// File: rtl/scan_scheduler.sv
// Ping-pong frame scheduler: the producer fills one RAM bank while an argmax engine
// scans the other; tracks pending/overrun frames, run timeouts and the latched peak.
module scan_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int TIMEOUT    = 2**ADDR_WIDTH + 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  frame_done,
    output logic [ADDR_WIDTH-1:0] bank0_addr,
    output logic                  bank0_we,
    output logic [DATA_WIDTH-1:0] bank0_wdata,
    input  logic [DATA_WIDTH-1:0] bank0_rdata,
    output logic [ADDR_WIDTH-1:0] bank1_addr,
    output logic                  bank1_we,
    output logic [DATA_WIDTH-1:0] bank1_wdata,
    input  logic [DATA_WIDTH-1:0] bank1_rdata,
    output logic                  am_start,
    input  logic [ADDR_WIDTH-1:0] am_addr,
    output logic [DATA_WIDTH-1:0] am_data,
    input  logic [DATA_WIDTH-1:0] am_max,
    input  logic [ADDR_WIDTH-1:0] am_index,
    input  logic                  am_valid,
    output logic                  wr_bank,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] peak_value,
    output logic [ADDR_WIDTH-1:0] peak_index,
    output logic                  peak_valid,
    output logic                  timeout_err,
    output logic [7:0]            overrun_count
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic                  wr_bank_r;
    logic                  pending_r;
    logic                  am_valid_q_r;
    logic [CNT_W-1:0]      run_cnt_r;
    logic [DATA_WIDTH-1:0] peak_value_r;
    logic [ADDR_WIDTH-1:0] peak_index_r;
    logic                  peak_valid_r;
    logic                  timeout_err_r;
    logic [7:0]            overrun_r;
    logic                  done_s;
    logic                  expire_s;
    logic                  exit_s;
    logic                  launch_s;

    // Run-end and launch conditions; only a rising am_valid edge completes a run.
    always_comb begin
        done_s   = (state_r == RUN) && am_valid && !am_valid_q_r;
        expire_s = (state_r == RUN) && !done_s && (run_cnt_r == CNT_W'(TIMEOUT - 1));
        exit_s   = done_s || expire_s;
        launch_s = ((state_r == IDLE) || exit_s) && (pending_r || frame_done);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = launch_s ? START : IDLE;
            START:   state_s = RUN;
            RUN: begin
                if (exit_s) begin
                    state_s = launch_s ? START : IDLE;
                end else begin
                    state_s = RUN;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Bank ownership, pending/overrun bookkeeping, run counter and result latching.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_bank_r     <= 1'b0;
            pending_r     <= 1'b0;
            am_valid_q_r  <= 1'b0;
            run_cnt_r     <= {CNT_W{1'b0}};
            peak_value_r  <= {DATA_WIDTH{1'b0}};
            peak_index_r  <= {ADDR_WIDTH{1'b0}};
            peak_valid_r  <= 1'b0;
            timeout_err_r <= 1'b0;
            overrun_r     <= 8'd0;
        end else begin
            am_valid_q_r  <= am_valid;
            peak_valid_r  <= done_s;
            timeout_err_r <= expire_s;
            if (done_s) begin
                peak_value_r <= am_max;
                peak_index_r <= am_index;
            end else begin
                peak_value_r <= peak_value_r;
                peak_index_r <= peak_index_r;
            end
            if (state_r == RUN) begin
                run_cnt_r <= run_cnt_r + CNT_W'(1);
            end else begin
                run_cnt_r <= {CNT_W{1'b0}};
            end
            // A frame finishing while the reader is busy waits; a second one overwrites it.
            if (launch_s) begin
                wr_bank_r <= ~wr_bank_r;
                pending_r <= 1'b0;
            end else if (frame_done && (state_r != IDLE)) begin
                if (pending_r) begin
                    if (overrun_r != 8'hFF) begin
                        overrun_r <= overrun_r + 8'd1;
                    end else begin
                        overrun_r <= overrun_r;
                    end
                end else begin
                    pending_r <= 1'b1;
                end
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Output decode and bank multiplexing.
    always_comb begin
        am_start      = (state_r == START);
        busy          = (state_r == START) || (state_r == RUN);
        wr_bank       = wr_bank_r;
        peak_value    = peak_value_r;
        peak_index    = peak_index_r;
        peak_valid    = peak_valid_r;
        timeout_err   = timeout_err_r;
        overrun_count = overrun_r;
        bank0_addr    = am_addr;
        bank0_we      = 1'b0;
        bank0_wdata   = {DATA_WIDTH{1'b0}};
        bank1_addr    = am_addr;
        bank1_we      = 1'b0;
        bank1_wdata   = {DATA_WIDTH{1'b0}};
        if (wr_bank_r == 1'b0) begin
            bank0_addr  = wr_addr;
            bank0_we    = wr_en;
            bank0_wdata = wr_data;
            am_data     = bank1_rdata;
        end else begin
            bank1_addr  = wr_addr;
            bank1_we    = wr_en;
            bank1_wdata = wr_data;
            am_data     = bank0_rdata;
        end
    end
endmodule
